// File: rtl/filter_sequencer.sv
// Frame controller for the 3-row morphological filter: streams ROM rows into the
// line buffers, writes filtered rows to RAM, pads top/bottom edges with zeros.
module filter_sequencer #(
  parameter int ROWS = 48,
  parameter int AW   = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          erosion_in,
  input  logic          kernelcross_in,
  input  logic          ram_gnt,
  output logic          busy,
  output logic          done,
  output logic          erosion,
  output logic          kernelcross,
  output logic [AW-1:0] rom_addr,
  output logic          rom_rd,
  output logic          filt_clear,
  output logic          filt_shift,
  output logic          filt_zero,
  output logic          ram_req,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
  localparam logic [AW-1:0] PENULT   = AW'(ROWS - 2);

  logic [2:0]    state;
  logic [AW-1:0] r;
  logic [AW:0]   r_plus2;
  logic          prefetch_ok;

  // One extra bit so r+2 cannot wrap when ROWS equals 2^AW.
  assign r_plus2     = {1'b0, r} + (AW+1)'(2);
  assign prefetch_ok = (r_plus2 < (AW+1)'(ROWS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      r           <= '0;
      erosion     <= 1'b0;
      kernelcross <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            erosion     <= erosion_in;
            kernelcross <= kernelcross_in;
            state       <= S_PRIME;
          end
        end
        S_PRIME: begin
          r     <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          if (ram_gnt) begin
            r <= r + AW'(1);
            if (r == PENULT) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (ram_gnt) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    rom_addr   = '0;
    rom_rd     = 1'b0;
    filt_clear = 1'b0;
    filt_shift = 1'b0;
    filt_zero  = 1'b0;
    ram_req    = 1'b0;
    ram_addr   = '0;
    case (state)
      S_IDLE: begin
        filt_clear = start;
        rom_rd     = start;
      end
      S_PRIME: begin
        busy       = 1'b1;
        filt_shift = 1'b1;
        rom_addr   = AW'(1);
        rom_rd     = 1'b1;
      end
      S_RUN: begin
        busy       = 1'b1;
        ram_req    = 1'b1;
        ram_addr   = r;
        filt_shift = ram_gnt;
        // Address stays pinned to the last row once prefetching has finished.
        rom_addr   = prefetch_ok ? r_plus2[AW-1:0] : LAST_ROW;
        rom_rd     = ram_gnt & prefetch_ok;
      end
      S_FLUSH: begin
        busy      = 1'b1;
        ram_req   = 1'b1;
        ram_addr  = r;
        filt_zero = 1'b1;
        rom_addr  = LAST_ROW;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign ram_we = ram_req & ram_gnt;

endmodule

// File: tb/tb_filter_sequencer.sv
// Bench for filter_sequencer: a 32-column ROM/filter/RAM harness around the default
// instance checked against a 2-D morphology reference, plus a ROWS=2 instance.
module tb_filter_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, erosion_in = 1'b0, kernelcross_in = 1'b0, ram_gnt = 1'b0;
  logic busy, done, erosion, kernelcross, rom_rd, filt_clear, filt_shift, filt_zero;
  logic ram_req, ram_we;
  logic [6:0] rom_addr, ram_addr;

  logic start2 = 1'b0;
  logic gnt2 = 1'b1;
  logic zero2 = 1'b0;
  logic busy2, done2, erosion2, kernelcross2, rom_rd2, filt_clear2, filt_shift2, filt_zero2;
  logic ram_req2, ram_we2;
  logic [6:0] rom_addr2, ram_addr2;

  always #5 clk = ~clk;

  filter_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .erosion_in(erosion_in),
    .kernelcross_in(kernelcross_in), .ram_gnt(ram_gnt), .busy(busy), .done(done),
    .erosion(erosion), .kernelcross(kernelcross), .rom_addr(rom_addr), .rom_rd(rom_rd),
    .filt_clear(filt_clear), .filt_shift(filt_shift), .filt_zero(filt_zero),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr)
  );

  filter_sequencer #(.ROWS(2), .AW(7)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .erosion_in(zero2),
    .kernelcross_in(zero2), .ram_gnt(gnt2), .busy(busy2), .done(done2),
    .erosion(erosion2), .kernelcross(kernelcross2), .rom_addr(rom_addr2), .rom_rd(rom_rd2),
    .filt_clear(filt_clear2), .filt_shift(filt_shift2), .filt_zero(filt_zero2),
    .ram_req(ram_req2), .ram_we(ram_we2), .ram_addr(ram_addr2)
  );

  // Harness: synchronous ROM and a 3-row line-buffer filter driven by the DUT strobes.
  logic [31:0] rom_img [0:47];
  logic [31:0] ram_img [0:47];
  logic [31:0] rom_q, buf0, buf1, incoming, filt_out;

  always_ff @(posedge clk) begin
    if (rom_rd && rom_addr < 7'd48) rom_q <= rom_img[rom_addr];
    if (filt_clear) begin
      buf0 <= '0;
      buf1 <= '0;
    end else if (filt_shift) begin
      buf0 <= buf1;
      buf1 <= incoming;
    end
  end

  always_comb begin
    incoming = filt_zero ? 32'h0 : rom_q;
    filt_out = '0;
    if (kernelcross) begin
      if (erosion) filt_out = buf1 & buf0 & incoming & (buf1 << 1) & (buf1 >> 1);
      else         filt_out = buf1 | buf0 | incoming | (buf1 << 1) | (buf1 >> 1);
    end else begin
      if (erosion) filt_out = buf0 & (buf0 << 1) & (buf0 >> 1) & incoming & (incoming << 1)
                            & (incoming >> 1) & (buf1 << 1) & (buf1 >> 1);
      else         filt_out = buf0 | (buf0 << 1) | (buf0 >> 1) | incoming | (incoming << 1)
                            | (incoming >> 1) | (buf1 << 1) | (buf1 >> 1);
    end
  end

  int n_checks = 0;
  int n_err = 0;
  bit gnt_pat [0:299];
  int restart_c, toggle_c, rst_c, done_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit px(input int y, input int x);
    if (y < 0 || y > 47 || x < 0 || x > 31) return 1'b0;
    return rom_img[y][x];
  endfunction

  // Reference: zero-padded 2-D morphology; cross = centre+4-neighbours, ring = 8 neighbours.
  function automatic logic [31:0] ref_row(input int y, input bit ero, input bit kc);
    logic [31:0] row;
    for (int x = 0; x < 32; x++) begin
      bit acc = ero;
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++) begin
          bit in_k = kc ? (dy == 0 || dx == 0) : !(dy == 0 && dx == 0);
          if (in_k) acc = ero ? (acc & px(y + dy, x + dx)) : (acc | px(y + dy, x + dx));
        end
      row[x] = acc;
    end
    return row;
  endfunction

  task automatic run_frame(input bit ero, input bit kc, input string name);
    int exp_wc[$];
    int k, nr, exp_done;
    bit exp_we;
    // Writes land on the granted cycles from cycle 2 onward; done follows the last one.
    for (int cc = 2; cc < 260 && exp_wc.size() < 48; cc++) if (gnt_pat[cc]) exp_wc.push_back(cc);
    exp_done = exp_wc[47] + 1;
    for (int i = 0; i < 48; i++) ram_img[i] = 'x;
    k = 0;
    nr = 0;
    done_c = -1;
    for (int c = 0; c < 260; c++) begin
      @(posedge clk); #1;
      start          = (c == 0) || (c == restart_c);
      erosion_in     = (toggle_c >= 0 && c >= toggle_c) ? ~ero : ero;
      kernelcross_in = kc;
      ram_gnt        = gnt_pat[c];
      rst            = (c == rst_c);
      @(negedge clk);
      if (rst_c >= 0 && c == rst_c + 1) begin
        chk({name, " reset_outs"}, {busy, done, rom_rd, filt_clear, filt_shift, filt_zero,
            ram_req, ram_we, rom_addr, ram_addr, erosion, kernelcross}, 32'h0);
        start = 1'b0;
        return;
      end
      if (c == 0) chk({name, " start_strobes"}, {busy, filt_clear, rom_rd, rom_addr}, {1'b0, 1'b1, 1'b1, 7'd0});
      exp_we = (k < 48) ? (c == exp_wc[k]) : 1'b0;
      chk({name, " ram_we"}, ram_we, exp_we);
      if (ram_we) begin
        chk({name, " ram_addr"}, ram_addr, k);
        if (ram_addr < 7'd48) ram_img[ram_addr] = filt_out;
        k++;
      end
      if (rom_rd) begin
        chk({name, " rom_addr"}, rom_addr, nr);
        nr++;
      end
      chk({name, " busy"}, busy, (c >= 1 && c < exp_done));
      chk({name, " filt_zero"}, filt_zero, (c > exp_wc[46] && c <= exp_wc[47]));
      chk({name, " done"}, done, (c == exp_done));
      if (done) done_c = c;
      if (c == exp_done) break;
    end
    start = 1'b0;
    ram_gnt = 1'b0;
    chk({name, " writes"}, k, 48);
    chk({name, " rom_reads"}, nr, 48);
    chk({name, " done_cycle"}, done_c, exp_done);
    chk({name, " latched_op"}, {erosion, kernelcross}, {ero, kc});
    for (int y = 0; y < 48; y++) chk({name, " row"}, ram_img[y], ref_row(y, ero, kc));
    $display("frame %s ero=%0d kc=%0d done at cycle %0d", name, ero, kc, done_c);
  endtask

  task automatic fresh(input int gnt_low_pct);
    restart_c = -1;
    toggle_c  = -1;
    rst_c     = -1;
    for (int i = 0; i < 300; i++) gnt_pat[i] = ($urandom_range(99) >= gnt_low_pct);
  endtask

  task automatic random_image();
    for (int i = 0; i < 48; i++) rom_img[i] = $urandom | $urandom;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {busy, done, rom_rd, filt_clear, filt_shift, filt_zero, ram_req, ram_we,
        rom_addr, ram_addr, erosion, kernelcross}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_state", {busy, done, ram_req, ram_we, busy2, done2}, 32'h0);

    // 5x5 block eroded by the cross kernel shrinks to 3x3.
    for (int i = 0; i < 48; i++) rom_img[i] = (i >= 10 && i <= 14) ? 32'h01F0_0000 : 32'h0;
    fresh(0);
    run_frame(1'b1, 1'b1, "block");
    chk("block_done50", done_c, 50);
    chk("block_r11", ram_img[11], 32'h00E0_0000);
    chk("block_r12", ram_img[12], 32'h00E0_0000);
    chk("block_r13", ram_img[13], 32'h00E0_0000);
    chk("block_r10", ram_img[10], 32'h0);
    chk("block_r14", ram_img[14], 32'h0);
    chk("block_r0", ram_img[0], 32'h0);
    chk("block_r47", ram_img[47], 32'h0);

    // Three-cycle grant stall while r=5 (cycle 7).
    random_image();
    fresh(0);
    for (int i = 7; i <= 9; i++) gnt_pat[i] = 1'b0;
    run_frame(1'b0, 1'b0, "stall");
    chk("stall_done53", done_c, 53);

    // Start re-pulsed mid-frame and erosion_in toggled: both ignored.
    random_image();
    fresh(0);
    restart_c = 10;
    toggle_c  = 5;
    run_frame(1'b1, 1'b0, "restart");

    // Reset at r=20, then a clean frame must not see stale buffer data.
    random_image();
    fresh(0);
    rst_c = 22;
    run_frame(1'b0, 1'b1, "rst_abort");
    random_image();
    fresh(0);
    run_frame(1'b0, 1'b1, "after_rst");

    for (int t = 0; t < 4; t++) begin
      bit e, kk;
      random_image();
      fresh(30);
      e  = 1'($urandom_range(1));
      kk = 1'($urandom_range(1));
      run_frame(e, kk, "random");
    end

    // ROWS=2: PRIME, one RUN, FLUSH, done at cycle 4.
    @(posedge clk); #1; start2 = 1'b1;
    @(negedge clk);
    chk("r2_c0", {busy2, filt_clear2, rom_rd2, rom_addr2}, {1'b0, 1'b1, 1'b1, 7'd0});
    @(posedge clk); #1; start2 = 1'b0;
    @(negedge clk);
    chk("r2_c1", {busy2, filt_shift2, rom_rd2, rom_addr2, ram_req2}, {1'b1, 1'b1, 1'b1, 7'd1, 1'b0});
    @(posedge clk); #1;
    @(negedge clk);
    chk("r2_c2", {busy2, ram_we2, ram_addr2, rom_rd2, filt_zero2}, {1'b1, 1'b1, 7'd0, 1'b0, 1'b0});
    @(posedge clk); #1;
    @(negedge clk);
    chk("r2_c3", {ram_we2, ram_addr2, filt_zero2, done2, rom_rd2}, {1'b1, 7'd1, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    @(negedge clk);
    chk("r2_c4", {done2, busy2, ram_we2}, {1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    @(negedge clk);
    chk("r2_c5", {done2, busy2}, {1'b0, 1'b0});
    $display("frame rows2 done at cycle 4 checked");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
